// File: rtl/jb_prach_nco_phase_gen.sv
// Per-antenna phase-accumulator NCO for the PRACH frequency-shift path.
// One phase word is emitted per TDM slot, NCO_LATENCY enabled cycles after the slot.
module jb_prach_nco_phase_gen #(
  parameter int  N_ANTENNAS  = 4,
  parameter int  PHASE_W     = 24,
  parameter int  NCO_LATENCY = 3,
  localparam int ID_W        = (N_ANTENNAS > 1) ? $clog2(N_ANTENNAS) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          clk_en,
  input  logic                          tvalid_in,
  input  logic                          sof_in,
  input  logic [N_ANTENNAS*PHASE_W-1:0] fcw_in,
  output logic                          tvalid_out,
  output logic [ID_W-1:0]               tuser_out,
  output logic [PHASE_W-1:0]            phase_out,
  output logic                          align_err
);

  localparam logic [ID_W-1:0] ANT_LAST      = ID_W'(N_ANTENNAS - 1);
  localparam logic [ID_W-1:0] ANT_AFTER_SOF = ID_W'(1 % N_ANTENNAS);

  function automatic logic [PHASE_W-1:0] phase_wrap_add(input logic [PHASE_W-1:0] a,
                                                        input logic [PHASE_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic [PHASE_W-1:0] fcw_sel(input logic [N_ANTENNAS*PHASE_W-1:0] bus,
                                                 input int idx);
    return bus[idx*PHASE_W +: PHASE_W];
  endfunction

  logic [PHASE_W-1:0] acc_q [N_ANTENNAS];
  logic [PHASE_W-1:0] acc_d [N_ANTENNAS];
  logic [ID_W-1:0]    ant_q, ant_d;
  logic               err_q, err_d;
  logic               beat;

  logic               vld_p0_d;
  logic [ID_W-1:0]    id_p0_d;
  logic [PHASE_W-1:0] ph_p0_d;

  logic               pipe_vld_q [NCO_LATENCY];
  logic [ID_W-1:0]    pipe_id_q  [NCO_LATENCY];
  logic [PHASE_W-1:0] pipe_ph_q  [NCO_LATENCY];

  // Stage 0: slot decode and accumulator update; phase emitted is pre-increment.
  always_comb begin
    beat     = tvalid_in & clk_en;
    acc_d    = acc_q;
    ant_d    = ant_q;
    err_d    = err_q;
    vld_p0_d = beat;
    id_p0_d  = pipe_id_q[0];
    ph_p0_d  = pipe_ph_q[0];
    if (beat) begin
      if (sof_in) begin
        for (int a = 0; a < N_ANTENNAS; a++) acc_d[a] = '0;
        acc_d[0] = fcw_sel(fcw_in, 0);
        ant_d    = ANT_AFTER_SOF;
        if (ant_q != '0) err_d = 1'b1;
        id_p0_d  = '0;
        ph_p0_d  = '0;
      end else begin
        acc_d[ant_q] = phase_wrap_add(acc_q[ant_q], fcw_sel(fcw_in, int'(ant_q)));
        ant_d        = (ant_q == ANT_LAST) ? '0 : ant_q + 1'b1;
        id_p0_d      = ant_q;
        ph_p0_d      = acc_q[ant_q];
      end
    end
  end

  // Stages 1..NCO_LATENCY-1: delay line matched to the FFT data path.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int a = 0; a < N_ANTENNAS; a++) acc_q[a] <= '0;
      for (int i = 0; i < NCO_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_id_q[i]  <= '0;
        pipe_ph_q[i]  <= '0;
      end
      ant_q <= '0;
      err_q <= 1'b0;
    end else if (clk_en) begin
      acc_q         <= acc_d;
      ant_q         <= ant_d;
      err_q         <= err_d;
      pipe_vld_q[0] <= vld_p0_d;
      pipe_id_q[0]  <= id_p0_d;
      pipe_ph_q[0]  <= ph_p0_d;
      for (int i = 1; i < NCO_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
        pipe_ph_q[i]  <= pipe_ph_q[i-1];
      end
    end
  end

  assign tvalid_out = pipe_vld_q[NCO_LATENCY-1];
  assign tuser_out  = pipe_id_q[NCO_LATENCY-1];
  assign phase_out  = pipe_ph_q[NCO_LATENCY-1];
  assign align_err  = err_q;

endmodule
